// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: response
// states and the starvation-counter width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_state_e;

    // Counter must hold 0..limit inclusive; never narrower than one bit.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data ports onto one single-port memory.
// Data wins by default; fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_sel,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_sel,
    input  logic [31:0]       mem_rdata,

    output logic              stall_o
);

    localparam int               CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    rsp_state_e       r_state;
    rsp_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_if_gnt;
    logic             w_d_gnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == LIMIT);

    // Grants are suppressed while rst is high so nothing reaches memory that cycle.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!rst) begin
            if (d_req && !(if_req && w_starved)) begin
                w_d_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_ce    = w_if_gnt | w_d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        if (w_if_gnt) begin
            mem_addr = if_addr;
            mem_sel  = 4'hF;
        end else if (w_d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_sel   = d_sel;
        end
    end

    always_comb begin
        w_state_nxt  = RSP_NONE;
        w_starve_nxt = r_starve_cnt;
        if (w_if_gnt) begin
            w_state_nxt = RSP_IF;
        end else if (w_d_gnt && !d_we) begin
            w_state_nxt = RSP_D;
        end
        if (w_if_gnt || !if_req) begin
            w_starve_nxt = '0;
        end else if (w_d_gnt && !w_starved) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RSP_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = !rst && (r_state == RSP_IF);
    assign d_rvalid  = !rst && (r_state == RSP_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
    assign stall_o   = !rst && ((if_req && !w_if_gnt) || (d_req && !w_d_gnt));

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: one vector per clock, grant-side outputs
// checked directly, read responses checked through a cycle-tagged scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_sel;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sel;
    logic        stall_o;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_sel;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_stall;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        is_if;
        logic [31:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sel(d_sel), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h2401_0001 : ((a ^ 32'hA5A5_0000) + 32'h11);
    endfunction

    // Memory model: read data one cycle after a read command, garbage otherwise.
    always @(posedge clk) begin
        if (mem_ce && !mem_we) mem_rdata <= mem_fn(mem_addr);
        else                   mem_rdata <= $urandom;
    end

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dwe, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [3:0] ds,
                                input logic eig, input logic edg, input logic est);
        vec_t v;
        v.rst = r; v.if_req = ir; v.if_addr = ia;
        v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd; v.d_sel = ds;
        v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_stall = est;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
            n_miscompares++;
        end
    endtask

    task automatic idle(input logic r);
        vecs.push_back(mk(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        vec_t        v;
        rsp_t        r;
        logic        e_ce, e_we, e_ifv, e_dv;
        logic [31:0] e_addr, e_wdata, e_ifd, e_dd;
        logic [3:0]  e_sel;

        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_sel = 0; mem_rdata = 0;

        // Reset with fetch held, then granted on the first cycle out of reset.
        vecs.push_back(mk(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0));
        idle(0);
        // Contention: data first, fetch once data drops.
        vecs.push_back(mk(0, 1, 32'h104, 1, 0, 32'h200, 0, 4'hF, 0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0));
        idle(0);
        // Data write: payload on the bus, no read response.
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 0, 1, 0));
        idle(0);
        // Starvation: ten cycles of data with fetch pending.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 32'h500, 1, 0, 32'h400, 0, 4'hF, 0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h500, 1, 0, 32'h400, 0, 4'hF, 1, 0, 1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 32'h504, 1, 0, 32'h404, 0, 4'hF, 0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h504, 1, 0, 32'h404, 0, 4'hF, 1, 0, 1));
        idle(0);
        // Reset right after a fetch grant drops its response; held data request resumes.
        vecs.push_back(mk(0, 1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h700, 0, 4'h5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h700, 0, 4'h5, 0, 1, 0));
        // Alternating single requests, back to back.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                vecs.push_back(mk(0, 1, 32'h800 + 4 * k, 0, 0, 0, 0, 0, 1, 0, 0));
            else
                vecs.push_back(mk(0, 0, 0, 1, 0, 32'h900 + 4 * k, 32'h1234_0000 + k, 4'hC, 0, 1, 0));
        end
        idle(0);
        idle(0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
            d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr;
            d_wdata = v.d_wdata; d_sel = v.d_sel;

            if (v.rst) while (sb.size() > 0 && sb[0].cyc == i) void'(sb.pop_front());
            if (v.e_if_gnt)
                sb.push_back('{cyc: i + 1, is_if: 1'b1, data: mem_fn(v.if_addr)});
            else if (v.e_d_gnt && !v.d_we)
                sb.push_back('{cyc: i + 1, is_if: 1'b0, data: mem_fn(v.d_addr)});

            e_ce    = v.e_if_gnt | v.e_d_gnt;
            e_we    = v.e_d_gnt & v.d_we;
            e_addr  = v.e_if_gnt ? v.if_addr : (v.e_d_gnt ? v.d_addr : 32'h0);
            e_wdata = v.e_d_gnt ? v.d_wdata : 32'h0;
            e_sel   = v.e_if_gnt ? 4'hF : (v.e_d_gnt ? v.d_sel : 4'h0);

            e_ifv = 1'b0; e_dv = 1'b0; e_ifd = 32'h0; e_dd = 32'h0;
            if (sb.size() > 0 && sb[0].cyc == i) begin
                r = sb.pop_front();
                if (r.is_if) begin e_ifv = 1'b1; e_ifd = r.data; end
                else         begin e_dv  = 1'b1; e_dd  = r.data; end
            end

            @(negedge clk);
            check("if_gnt",    i, 32'(if_gnt),    32'(v.e_if_gnt));
            check("d_gnt",     i, 32'(d_gnt),     32'(v.e_d_gnt));
            check("stall_o",   i, 32'(stall_o),   32'(v.e_stall));
            check("mem_ce",    i, 32'(mem_ce),    32'(e_ce));
            check("mem_we",    i, 32'(mem_we),    32'(e_we));
            check("mem_addr",  i, mem_addr,       e_addr);
            check("mem_wdata", i, mem_wdata,      e_wdata);
            check("mem_sel",   i, 32'(mem_sel),   32'(e_sel));
            check("if_rvalid", i, 32'(if_rvalid), 32'(e_ifv));
            check("if_rdata",  i, if_rdata,       e_ifd);
            check("d_rvalid",  i, 32'(d_rvalid),  32'(e_dv));
            check("d_rdata",   i, d_rdata,        e_dd);
            n_vectors++;
        end

        check("sb_drained", vecs.size(), sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
